// File: rtl/aud_channel_out.sv
// Audio channel output stage: distortion selection against shared polynomial
// counters, optional high-pass on channels 1/2, per-channel volume and a registered sum.
module aud_channel_out (
  input  logic       clk,
  input  logic       reset,
  input  logic       enp,
  input  logic [7:0] D,
  input  logic       Addr1w,
  input  logic       Addr3w,
  input  logic       Addr5w,
  input  logic       Addr7w,
  input  logic       Addr8w,
  input  logic [4:1] Timer,
  input  logic       rstAudPhase,
  output logic [4:1] chBit,
  output logic [5:0] AudOut
);

  logic [4:1][7:0] audc_reg;
  logic [7:0]      audctl_reg;
  logic [3:0]      poly4_reg;
  logic [4:0]      poly5_reg;
  logic [8:0]      poly9_reg;
  logic [16:0]     poly17_reg;
  logic [4:1]      tf_reg;
  logic            hp1_reg;
  logic            hp2_reg;
  logic [5:0]      aud_out_reg;

  logic [4:1]      wr;
  logic [4:1]      tf_next;
  logic [4:1][5:0] lvl;
  logic            poly_n;
  logic [5:0]      sum_next;

  assign wr     = {Addr7w, Addr5w, Addr3w, Addr1w};
  assign poly_n = audctl_reg[7] ? poly9_reg[0] : poly17_reg[0];

  assign chBit[1] = audctl_reg[2] ? (tf_reg[1] ^ hp1_reg) : tf_reg[1];
  assign chBit[2] = audctl_reg[1] ? (tf_reg[2] ^ hp2_reg) : tf_reg[2];
  assign chBit[3] = tf_reg[3];
  assign chBit[4] = tf_reg[4];

  // Per-channel tone decision and volume gating; poly outputs are the pre-shift values.
  for (genvar gi = 1; gi <= 4; gi++) begin : g_chan
    assign tf_next[gi] = (!audc_reg[gi][7] && !poly5_reg[0]) ? tf_reg[gi] :
                         audc_reg[gi][5] ? ~tf_reg[gi] :
                         audc_reg[gi][6] ? poly4_reg[0] : poly_n;
    assign lvl[gi] = (audc_reg[gi][4] | chBit[gi]) ? {2'b00, audc_reg[gi][3:0]} : 6'd0;
  end

  assign sum_next = lvl[1] + lvl[2] + lvl[3] + lvl[4];

  always_ff @(posedge clk) begin
    if (reset) begin
      audc_reg    <= '0;
      audctl_reg  <= '0;
      poly4_reg   <= '0;
      poly5_reg   <= '0;
      poly9_reg   <= '0;
      poly17_reg  <= '0;
      tf_reg      <= '0;
      hp1_reg     <= 1'b0;
      hp2_reg     <= 1'b0;
      aud_out_reg <= '0;
    end else if (enp) begin
      for (int i = 1; i <= 4; i++) begin
        if (wr[i]) audc_reg[i] <= D;
      end
      if (Addr8w) audctl_reg <= D;

      // Right-shifting LFSRs with XNOR feedback, so all-zeros is a legal start state.
      poly4_reg  <= {~(poly4_reg[0]  ^ poly4_reg[1]),  poly4_reg[3:1]};
      poly5_reg  <= {~(poly5_reg[0]  ^ poly5_reg[2]),  poly5_reg[4:1]};
      poly9_reg  <= {~(poly9_reg[0]  ^ poly9_reg[4]),  poly9_reg[8:1]};
      poly17_reg <= {~(poly17_reg[0] ^ poly17_reg[5]), poly17_reg[16:1]};

      if (rstAudPhase) begin
        tf_reg  <= '0;
        hp1_reg <= 1'b0;
        hp2_reg <= 1'b0;
      end else begin
        for (int i = 1; i <= 4; i++) begin
          if (Timer[i]) tf_reg[i] <= tf_next[i];
        end
        if (Timer[3]) hp1_reg <= tf_reg[1];
        if (Timer[4]) hp2_reg <= tf_reg[2];
      end

      aud_out_reg <= sum_next;
    end
  end

  assign AudOut = aud_out_reg;

endmodule

// File: tb/tb_aud_channel_out.sv
// Directed bench for aud_channel_out: vector table for tone/volume/high-pass/phase
// reset, then hand sequences for write/Timer collision against a poly model and reset priority.
module tb_aud_channel_out;

  logic       clk = 1'b0;
  logic       reset;
  logic       enp;
  logic [7:0] D;
  logic       Addr1w, Addr3w, Addr5w, Addr7w, Addr8w;
  logic [4:1] Timer;
  logic       rstAudPhase;
  logic [4:1] chBit;
  logic [5:0] AudOut;

  int checks = 0;
  int failures = 0;

  logic [4:0]  m5;
  logic [16:0] m17;

  aud_channel_out dut (
    .clk(clk), .reset(reset), .enp(enp), .D(D),
    .Addr1w(Addr1w), .Addr3w(Addr3w), .Addr5w(Addr5w), .Addr7w(Addr7w), .Addr8w(Addr8w),
    .Timer(Timer), .rstAudPhase(rstAudPhase), .chBit(chBit), .AudOut(AudOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [4:0] wr;   // {Addr8w, Addr7w, Addr5w, Addr3w, Addr1w}
    logic [7:0] d;
    logic [4:1] t;
    logic       rph;
    logic [4:1] exp_ch;
    logic [5:0] exp_out;
  } vec_t;

  localparam logic [4:0] W0 = 5'b00000, W1 = 5'b00001, W2 = 5'b00010,
                         W3 = 5'b00100, W4 = 5'b01000, WC = 5'b10000;

  vec_t vecs [34];

  function automatic vec_t mk(input logic en, input logic [4:0] wr, input logic [7:0] d,
                              input logic [4:1] t, input logic rph,
                              input logic [4:1] ch, input logic [5:0] out);
    vec_t v;
    v.en = en; v.wr = wr; v.d = d; v.t = t; v.rph = rph; v.exp_ch = ch; v.exp_out = out;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // One clock: drive, take the edge, advance the independent poly model, settle.
  task automatic step(input logic en_i, input logic [4:0] wr_i, input logic [7:0] d_i,
                      input logic [4:1] t_i, input logic rph_i);
    enp = en_i;
    {Addr8w, Addr7w, Addr5w, Addr3w, Addr1w} = wr_i;
    D = d_i;
    Timer = t_i;
    rstAudPhase = rph_i;
    @(posedge clk);
    if (reset) begin
      m5 = '0;
      m17 = '0;
    end else if (en_i) begin
      m5  = {~(m5[0] ^ m5[2]), m5[4:1]};
      m17 = {~(m17[0] ^ m17[5]), m17[16:1]};
    end
    #1;
  endtask

  initial begin
    logic tf2;
    logic exp_tf2;

    reset = 1'b1;
    m5 = '0;
    m17 = '0;
    step(1'b1, W0, 8'h00, 4'b0000, 1'b0);
    step(1'b1, W0, 8'h00, 4'b0000, 1'b0);
    reset = 1'b0;
    step(1'b1, W0, 8'h00, 4'b0000, 1'b0);
    $display("reset: chBit=%b AudOut=%0d", chBit, AudOut);
    chk("reset_audout", AudOut, 0);
    chk("reset_chbit", chBit, 0);

    // Pure tone, enp hold, volume-only sum, phase reset, high-pass.
    vecs[0]  = mk(1, W1, 8'hAF, 4'b0000, 0, 4'b0000, 0);
    vecs[1]  = mk(1, W0, 8'h00, 4'b0000, 0, 4'b0000, 0);
    vecs[2]  = mk(1, W0, 8'h00, 4'b0001, 0, 4'b0001, 0);
    vecs[3]  = mk(1, W0, 8'h00, 4'b0000, 0, 4'b0001, 15);
    vecs[4]  = mk(1, W0, 8'h00, 4'b0000, 0, 4'b0001, 15);
    vecs[5]  = mk(1, W0, 8'h00, 4'b0000, 0, 4'b0001, 15);
    vecs[6]  = mk(1, W0, 8'h00, 4'b0001, 0, 4'b0000, 15);
    vecs[7]  = mk(1, W0, 8'h00, 4'b0000, 0, 4'b0000, 0);
    vecs[8]  = mk(1, W0, 8'h00, 4'b0001, 0, 4'b0001, 0);
    vecs[9]  = mk(1, W0, 8'h00, 4'b0000, 0, 4'b0001, 15);
    vecs[10] = mk(0, W1, 8'h00, 4'b0001, 0, 4'b0001, 15);
    vecs[11] = mk(1, W0, 8'h00, 4'b0000, 0, 4'b0001, 15);
    vecs[12] = mk(1, W1, 8'h1F, 4'b0000, 0, 4'b0001, 15);
    vecs[13] = mk(1, W2, 8'h1F, 4'b0000, 0, 4'b0001, 15);
    vecs[14] = mk(1, W3, 8'h1F, 4'b0000, 0, 4'b0001, 30);
    vecs[15] = mk(1, W4, 8'h1F, 4'b0000, 0, 4'b0001, 45);
    vecs[16] = mk(1, W0, 8'h00, 4'b0000, 0, 4'b0001, 60);
    vecs[17] = mk(1, W1, 8'hAF, 4'b0000, 0, 4'b0001, 60);
    vecs[18] = mk(1, W2, 8'h00, 4'b0000, 0, 4'b0001, 60);
    vecs[19] = mk(1, W3, 8'hA0, 4'b0000, 0, 4'b0001, 45);
    vecs[20] = mk(1, W4, 8'h00, 4'b0000, 0, 4'b0001, 30);
    vecs[21] = mk(1, W0, 8'h00, 4'b0000, 0, 4'b0001, 15);
    vecs[22] = mk(1, W0, 8'h00, 4'b0001, 1, 4'b0000, 15);
    vecs[23] = mk(1, W0, 8'h00, 4'b0000, 0, 4'b0000, 0);
    vecs[24] = mk(1, WC, 8'h04, 4'b0000, 0, 4'b0000, 0);
    vecs[25] = mk(1, W1, 8'hA8, 4'b0000, 0, 4'b0000, 0);
    vecs[26] = mk(1, W0, 8'h00, 4'b0101, 0, 4'b0101, 0);
    vecs[27] = mk(1, W0, 8'h00, 4'b0000, 0, 4'b0101, 8);
    vecs[28] = mk(1, W0, 8'h00, 4'b0101, 0, 4'b0001, 8);
    vecs[29] = mk(1, W0, 8'h00, 4'b0000, 0, 4'b0001, 8);
    vecs[30] = mk(1, W0, 8'h00, 4'b0001, 0, 4'b0000, 8);
    vecs[31] = mk(1, W0, 8'h00, 4'b0000, 0, 4'b0000, 0);
    vecs[32] = mk(1, W0, 8'h00, 4'b0001, 0, 4'b0001, 0);
    vecs[33] = mk(1, W0, 8'h00, 4'b0000, 0, 4'b0001, 8);

    for (int i = 0; i < 34; i++) begin
      step(vecs[i].en, vecs[i].wr, vecs[i].d, vecs[i].t, vecs[i].rph);
      $display("vec %0d: en=%b wr=%b d=%h t=%b rph=%b -> chBit=%b AudOut=%0d (exp %b/%0d)",
               i, vecs[i].en, vecs[i].wr, vecs[i].d, vecs[i].t, vecs[i].rph,
               chBit, AudOut, vecs[i].exp_ch, vecs[i].exp_out);
      chk($sformatf("vec%0d_chbit", i), chBit, vecs[i].exp_ch);
      chk($sformatf("vec%0d_audout", i), AudOut, vecs[i].exp_out);
    end

    // Write/Timer collision: old distortion (toggle) applies on the colliding pulse.
    step(1'b1, W2, 8'hA5, 4'b0000, 1'b0);
    $display("collision setup: chBit=%b", chBit);
    chk("coll_setup_ch2", chBit[2], 0);
    step(1'b1, W2, 8'h05, 4'b0010, 1'b0);
    $display("collision pulse: chBit=%b", chBit);
    chk("coll_toggle_ch2", chBit[2], 1);
    tf2 = 1'b1;

    // Further pulses use poly5-gated poly17 (AUDCTL[7]=0), sampled before the shift.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, W0, 8'h00, 4'b0000, 1'b0);
      exp_tf2 = (m5[0] == 1'b0) ? tf2 : m17[0];
      step(1'b1, W0, 8'h00, 4'b0010, 1'b0);
      tf2 = exp_tf2;
      $display("poly pulse %0d: chBit=%b exp_ch2=%b", k, chBit, tf2);
      chk($sformatf("poly%0d_ch2", k), chBit[2], tf2);
      step(1'b1, W0, 8'h00, 4'b0000, 1'b0);
      $display("poly pulse %0d: AudOut=%0d", k, AudOut);
      chk($sformatf("poly%0d_audout", k), AudOut, tf2 ? 13 : 8);
    end

    // Reset wins over a simultaneous write and Timer.
    reset = 1'b1;
    step(1'b1, W1 | W2, 8'h1F, 4'b1111, 1'b0);
    reset = 1'b0;
    step(1'b1, W0, 8'h00, 4'b0000, 1'b0);
    step(1'b1, W0, 8'h00, 4'b0000, 1'b0);
    $display("reset+write: chBit=%b AudOut=%0d", chBit, AudOut);
    chk("rstwin_audout", AudOut, 0);
    chk("rstwin_chbit", chBit, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
